// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its execution sequencer.
package instr_register_pkg;

  localparam int ADDR_W = 5;
  localparam int OPND_W = 32;

  typedef logic [ADDR_W-1:0] address_t;
  typedef logic signed [OPND_W-1:0] operand_t;

  typedef enum logic [2:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, EXEC, DIVIDE, OUTPUT
  } seq_state_t;

  // Number of divider cycles needed to resolve a full operand-width quotient
  function automatic int div_iters(input int bits_per_cycle);
    return OPND_W / bits_per_cycle;
  endfunction

endpackage

// File: rtl/instr_exec_sequencer_divider.sv
// Iterative restoring divider on operand magnitudes with a final sign fixup.
// Quotient truncates toward zero, remainder follows the dividend's sign.
module instr_iter_divider
  import instr_register_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     start,
  input  operand_t op_a,
  input  operand_t op_b,
  input  logic     is_mod,
  output logic     done,
  output result_t  value
);

  localparam int ITERS = div_iters(DIV_BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(ITERS + 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      quo, rem, dvs;
  logic [31:0]      quo_nxt, rem_nxt;
  logic [32:0]      trial;
  logic             neg_q, neg_r, mod_q, zero_q;
  result_t          q_mag, r_mag;

  function automatic logic [31:0] magnitude(input operand_t x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Resolve DIV_BITS_PER_CYCLE quotient bits per clock
  always_comb begin
    quo_nxt = quo;
    rem_nxt = rem;
    trial   = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      trial   = {rem_nxt, quo_nxt[31]};
      quo_nxt = {quo_nxt[30:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial      = trial - {1'b0, dvs};
        quo_nxt[0] = 1'b1;
      end
      rem_nxt = trial[31:0];
    end
  end

  // Iteration control; a zero divisor skips straight to done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= (op_b == '0) ? '0 : CNT_W'(ITERS);
    end else if (running && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operand magnitudes and partial quotient/remainder
  always_ff @(posedge clk) begin
    if (start) begin
      quo    <= magnitude(op_a);
      rem    <= '0;
      dvs    <= magnitude(op_b);
      neg_q  <= op_a[31] ^ op_b[31];
      neg_r  <= op_a[31];
      mod_q  <= is_mod;
      zero_q <= (op_b == '0);
    end else if (running && (cnt != '0)) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  assign done = running && (cnt == '0);

  // Sign fixup in 64 bits so the most-negative dividend cannot overflow
  always_comb begin
    q_mag = result_t'({32'b0, quo});
    r_mag = result_t'({32'b0, rem});
    if (zero_q)     value = '0;
    else if (mod_q) value = neg_r ? -r_mag : r_mag;
    else            value = neg_q ? -q_mag : q_mag;
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks a window of the instruction register stack, executes each word and
// streams the results out on a valid/ready port.
// Optional build macro EXEC_DIV0_FLAG_EN adds the div_zero output.
module instr_exec_sequencer
  import instr_register_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int MAX_COUNT          = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_addr,
  input  logic [5:0]   count,
  input  instruction_t instruction_word,
  output address_t     read_pointer,
  output logic         busy,
  output logic         done,
  output result_t      result,
  output opcode_t      result_opc,
  output address_t     result_addr,
  output logic         result_valid,
  input  logic         result_ready
`ifdef EXEC_DIV0_FLAG_EN
  ,
  output logic         div_zero
`endif
);

  seq_state_t state, state_nxt;
  logic [5:0] count_cl, left_q;
  opcode_t    opc_q;
  operand_t   op_a_q, op_b_q;
  logic       div_start, div_done, latch_res;
  result_t    div_value, exec_value, a64, b64;

  assign count_cl     = (count > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : count;
  assign busy         = (state != IDLE);
  assign result_valid = (state == OUTPUT);
  assign latch_res    = (state == EXEC) || ((state == DIVIDE) && div_done);

  instr_iter_divider #(
    .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (div_start),
    .op_a   (instruction_word.op_a),
    .op_b   (instruction_word.op_b),
    .is_mod (instruction_word.opc == MOD),
    .done   (div_done),
    .value  (div_value)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and divider launch
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      IDLE:    if (start && (count_cl != '0)) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: begin
        if ((instruction_word.opc == DIV) || (instruction_word.opc == MOD)) begin
          state_nxt = DIVIDE;
          div_start = 1'b1;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = OUTPUT;
      DIVIDE:  if (div_done) state_nxt = OUTPUT;
      OUTPUT:  if (result_ready) state_nxt = (left_q > 6'd1) ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ALU on sign-extended operands
  always_comb begin
    a64 = result_t'(op_a_q);
    b64 = result_t'(op_b_q);
    case (opc_q)
      PASSA:   exec_value = a64;
      PASSB:   exec_value = b64;
      ADD:     exec_value = a64 + b64;
      SUB:     exec_value = a64 - b64;
      MULT:    exec_value = a64 * b64;
      default: exec_value = '0;
    endcase
  end

  // Captured instruction fields
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      opc_q  <= instruction_word.opc;
      op_a_q <= instruction_word.op_a;
      op_b_q <= instruction_word.op_b;
    end
  end

  // Address walk, location count, result holding registers and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      left_q       <= '0;
      done         <= 1'b0;
      result       <= '0;
      result_opc   <= ZERO;
      result_addr  <= '0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start) begin
        if (count_cl == '0) begin
          done <= 1'b1;
        end else begin
          read_pointer <= first_addr;
          left_q       <= count_cl;
        end
      end
      if (latch_res) begin
        result      <= (state == DIVIDE) ? div_value : exec_value;
        result_opc  <= opc_q;
        result_addr <= read_pointer;
      end
      if ((state == OUTPUT) && result_ready) begin
        if (left_q > 6'd1) begin
          read_pointer <= read_pointer + 5'd1;
          left_q       <= left_q - 6'd1;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

`ifdef EXEC_DIV0_FLAG_EN
  // Divide-by-zero flag travels with the result it describes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       div_zero <= 1'b0;
    else if (latch_res) div_zero <= (state == DIVIDE) && (op_b_q == '0);
  end
`endif

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Directed bench for instr_exec_sequencer: a vector table walked as one
// sequence, plus hand-written latency, wrap, stall, count=0, clamp and
// reset-during-divide sequences.
module tb_instr_exec_sequencer;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n, start, result_ready;
  address_t     first_addr, read_pointer, result_addr;
  logic [5:0]   count;
  instruction_t instruction_word;
  logic         busy, done, result_valid;
  result_t      result;
  opcode_t      result_opc;
`ifdef EXEC_DIV0_FLAG_EN
  logic         div_zero;
`endif

  instruction_t mem [32];
  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  typedef struct {
    opcode_t  opc;
    operand_t a;
    operand_t b;
    result_t  exp;
    logic     dz;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  assign instruction_word = mem[read_pointer];

  instr_exec_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .first_addr      (first_addr),
    .count           (count),
    .instruction_word(instruction_word),
    .read_pointer    (read_pointer),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .result_opc      (result_opc),
    .result_addr     (result_addr),
    .result_valid    (result_valid),
    .result_ready    (result_ready)
`ifdef EXEC_DIV0_FLAG_EN
    ,
    .div_zero        (div_zero)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic launch(input address_t a, input logic [5:0] c);
    first_addr = a;
    count      = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // lat counts negedges since the cycle start was raised
  task automatic wait_valid(input int budget, inout int lat);
    while (result_valid !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (result_valid !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_valid: result_valid not seen within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, seen, stable, n;
    result_t exp_ab [3];

    tbl[0]  = '{ADD,   32'sd5,  32'sd7, 64'sd12, 1'b0};
    tbl[1]  = '{SUB,  -32'sd15, 32'sd3, -64'sd18, 1'b0};
    tbl[2]  = '{MULT, -32'sd4,  32'sd9, -64'sd36, 1'b0};
    tbl[3]  = '{ZERO,  32'sd3,  32'sd4, 64'sd0, 1'b0};
    tbl[4]  = '{PASSA, -32'sd8, 32'sd1, -64'sd8, 1'b0};
    tbl[5]  = '{PASSB, 32'sd2, -32'sd9, -64'sd9, 1'b0};
    tbl[6]  = '{DIV,  -32'sd15, 32'sd4, -64'sd3, 1'b0};
    tbl[7]  = '{MOD,  -32'sd15, 32'sd4, -64'sd3, 1'b0};
    tbl[8]  = '{DIV,   32'sd7,  32'sd0, 64'sd0, 1'b1};
    tbl[9]  = '{DIV,   32'sd100, -32'sd7, -64'sd14, 1'b0};
    tbl[10] = '{MOD,   32'sd100, -32'sd7, 64'sd2, 1'b0};
    tbl[11] = '{MULT,  32'sh7fffffff, 32'sh7fffffff, 64'sh3fffffff00000001, 1'b0};
    tbl[12] = '{ADD,   32'sh7fffffff, 32'sh7fffffff, 64'sd4294967294, 1'b0};
    tbl[13] = '{SUB,   32'sh80000000, 32'sd1, -64'sd2147483649, 1'b0};
    tbl[14] = '{MOD,  -32'sd7,  32'sd0, 64'sd0, 1'b1};
    tbl[15] = '{DIV,   32'sh80000000, 32'sd1, -64'sd2147483648, 1'b0};

    for (int i = 0; i < 32; i++) mem[i] = '{ZERO, 32'sd0, 32'sd0};

    reset_n = 1'b1; start = 1'b0; result_ready = 1'b1;
    first_addr = '0; count = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", result_valid, 0);
    check("rst_rp", read_pointer, 0);
    check("rst_result", result, 0);
    check("rst_opc", result_opc, ZERO);
    check("rst_addr", result_addr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Whole table as one sequence from address 0
    for (int i = 0; i < NV; i++) mem[i] = '{tbl[i].opc, tbl[i].a, tbl[i].b};
    launch(5'd0, 6'(NV));
    lat = 1;
    for (int i = 0; i < NV; i++) begin
      lat = 0;
      wait_valid(60, lat);
      check($sformatf("tbl%0d_result", i), result, tbl[i].exp);
      check($sformatf("tbl%0d_opc", i), 64'(result_opc), 64'(tbl[i].opc));
      check($sformatf("tbl%0d_addr", i), result_addr, i);
      if (tbl[i].dz) check($sformatf("tbl%0d_dz_result", i), result, 0);
`ifdef EXEC_DIV0_FLAG_EN
      check($sformatf("tbl%0d_div_zero", i), div_zero, tbl[i].dz);
`endif
      @(negedge clk);
    end
    check("tbl_done", done, 1);
    @(negedge clk);

    // ADD/SUB/MULT window at 2..4: latency and single done pulse
    mem[2] = '{ADD, 32'sd5, 32'sd7};
    mem[3] = '{SUB, -32'sd15, 32'sd3};
    mem[4] = '{MULT, -32'sd4, 32'sd9};
    exp_ab[0] = 64'sd12; exp_ab[1] = -64'sd18; exp_ab[2] = -64'sd36;
    d0 = done_cnt;
    launch(5'd2, 6'd3);
    lat = 1;
    wait_valid(20, lat);
    check("alu_latency", lat, 4);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin lat = 0; wait_valid(20, lat); end
      check($sformatf("alu%0d_result", k), result, exp_ab[k]);
      check($sformatf("alu%0d_addr", k), result_addr, 2 + k);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("alu_done_pulses", done_cnt - d0, 1);

    // Address wrap 30,31,0,1
    for (int k = 0; k < 4; k++) mem[(30 + k) % 32] = '{PASSA, 32'(100 + k), 32'sd0};
    launch(5'd30, 6'd4);
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      wait_valid(20, lat);
      check($sformatf("wrap%0d_rp", k), read_pointer, (30 + k) % 32);
      check($sformatf("wrap%0d_addr", k), result_addr, (30 + k) % 32);
      check($sformatf("wrap%0d_result", k), result, 100 + k);
      @(negedge clk);
    end
    @(negedge clk);

    // Divider latency and results
    mem[5] = '{DIV, -32'sd15, 32'sd4};
    launch(5'd5, 6'd1);
    lat = 1;
    wait_valid(80, lat);
    check("div_latency", lat, 36);
    check("div_result", result, -64'sd3);
    repeat (2) @(negedge clk);
    mem[5] = '{MOD, -32'sd15, 32'sd4};
    launch(5'd5, 6'd1);
    lat = 1;
    wait_valid(80, lat);
    check("mod_latency", lat, 36);
    check("mod_result", result, -64'sd3);
    repeat (2) @(negedge clk);
    mem[5] = '{DIV, 32'sd7, 32'sd0};
    launch(5'd5, 6'd1);
    lat = 1;
    wait_valid(80, lat);
    check("div0_latency", lat, 4);
    check("div0_result", result, 0);
`ifdef EXEC_DIV0_FLAG_EN
    check("div0_flag", div_zero, 1);
`endif
    repeat (2) @(negedge clk);

    // Backpressure stall with an ignored start
    mem[6] = '{ADD, 32'sd1, 32'sd2};
    mem[7] = '{SUB, 32'sd10, 32'sd4};
    result_ready = 1'b0;
    launch(5'd6, 6'd2);
    lat = 1;
    wait_valid(20, lat);
    check("stall_first", result, 64'sd3);
    stable = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin first_addr = 5'd20; count = 6'd1; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
      if (result_valid === 1'b1 && result === 64'sd3 && result_opc === ADD &&
          result_addr === 5'd6 && read_pointer === 5'd6) stable++;
    end
    check("stall_stable_cycles", stable, 5);
    result_ready = 1'b1;
    @(negedge clk);
    lat = 0;
    wait_valid(20, lat);
    check("stall_second", result, 64'sd6);
    check("stall_second_addr", result_addr, 7);
    @(negedge clk);
    check("stall_done", done, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("stall_start_ignored", seen, 0);

    // count = 0
    d0 = done_cnt;
    launch(5'd9, 6'd0);
    check("cnt0_done", done, 1);
    check("cnt0_busy", busy, 0);
    @(negedge clk);
    check("cnt0_done_off", done, 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0) seen++;
    end
    check("cnt0_busy_later", seen, 0);
    check("cnt0_rp", read_pointer, 7);
    check("cnt0_pulses", done_cnt - d0, 1);

    // count above MAX_COUNT is clamped to 32 locations
    launch(5'd0, 6'd40);
    n = 0;
    lat = 0;
    while (done !== 1'b1 && lat < 4000) begin
      if (result_valid === 1'b1) n++;
      @(negedge clk);
      lat++;
    end
    check("clamp_results", n, 32);
    @(negedge clk);

    // Reset in the middle of a divide
    mem[8] = '{DIV, 32'sd1000, 32'sd3};
    launch(5'd8, 6'd1);
    repeat (11) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstdiv_busy", busy, 0);
    check("rstdiv_valid", result_valid, 0);
    check("rstdiv_rp", read_pointer, 0);
    check("rstdiv_result", result, 0);
    check("rstdiv_addr", result_addr, 0);
    check("rstdiv_opc", result_opc, ZERO);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("rstdiv_no_result", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
